traffic_lamp_monitor: RTL and testbench
=======================================

// Module: traffic_lamp_monitor
// PURPOSE
//  Observes the six lamp outputs of the traffic-light controller and decodes them back into the 2-bit Gray state.
//  Checks that state sequence and phase durations are legal, measures each phase length, and latches a fault code.
//  Sits beside the controller top; runs on the undivided i_clk. All durations are in i_clk cycles.
// PARAMETERS
//  CNT_W      8  phase counter width; counter saturates at 2**CNT_W-1
//  MIN_LONG   8  minimum cycles for a green phase (G=00 or G=11)
//  MIN_SHORT  2  minimum cycles for a yellow phase (G=01 or G=10)
//  MAX_SHORT  6  maximum cycles a yellow phase may last (MAX_SHORT > MIN_SHORT)
//  FLASH_DIV  4  cycles per half-period of o_flash_red (used only with the flash option)
// PORTS
//  i_clk            in   1      clock
//  i_reset          in   1      synchronous active-high reset
//  i_clear          in   1      synchronous fault clear; returns monitor to INIT
//  i_Main_red       in   1      main road red lamp
//  i_Main_yellow    in   1      main road yellow lamp
//  i_Main_green     in   1      main road green lamp
//  i_Side_red       in   1      side road red lamp
//  i_Side_yellow    in   1      side road yellow lamp
//  i_Side_green     in   1      side road green lamp
//  o_G              out  2      decoded Gray state
//  o_valid          out  1      1 while in TRACK (o_G meaningful)
//  o_phase_done     out  1      1-cycle pulse on each legal transition
//  o_phase_len      out  CNT_W  length of the phase just ended; held until next pulse
//  o_fault          out  1      latched fault flag
//  o_fault_code     out  3      0 none, 1 illegal pattern, 2 illegal transition, 3 phase too short, 4 yellow timeout
//  o_flash_red      out  1      fail-safe flashing red drive
// BEHAVIOUR
//  Reset: all outputs 0; r_lamp=0; counter=0; FSM=INIT. i_reset has priority over i_clear.
//  Stage 1: the six lamps are registered into r_lamp every cycle.
//  Stage 2: r_lamp is decoded, and outputs are registered from it.
//   - A lamp change before edge N appears on the outputs after edge N+1 (2-cycle latency).
//  Legal patterns (MR,MY,MG,SR,SY,SG):
//   - 001100 -> G=00
//   - 010100 -> G=01
//   - 100001 -> G=11
//   - 100010 -> G=10
//   - Any other pattern, including all-red, is illegal.
//  Legal sequence: 00->01->11->10->00. Any other change between legal patterns is code 2.
//  FSM:
//   - INIT: ignore illegal patterns. On the first legal pattern, go to TRACK: load o_G, counter=1, o_valid=1.
//   - TRACK, same pattern: counter+1 (saturating). If o_G is yellow and counter reaches MAX_SHORT, fault code 4.
//   - TRACK, legal transition: o_phase_len=counter, o_phase_done=1, counter=1, o_G=new.
//     If the old green phase had counter<MIN_LONG, or the old yellow phase had counter<MIN_SHORT, fault code 3.
//     o_phase_done still pulses in that case.
//   - TRACK, illegal pattern: code 1. Illegal transition: code 2, with no o_phase_done.
//   - FAULT: o_fault=1, o_valid=0, and o_fault_code is held. o_G is frozen at its last value.
//     The counter stops. Only i_reset or i_clear leave FAULT.
//  Fault entry: o_fault and o_fault_code are set on the same edge as the offending o_G update.
//  Simultaneous conditions: the lowest nonzero code wins.
//  i_clear:
//   - In any state, next state is INIT.
//   - Clears o_fault, o_fault_code, o_valid and the counter.
//   - o_phase_len and o_G are held.
//   - A lamp event in the same cycle as i_clear is discarded.
// CONFIGURATION
//  TRAFFIC_MON_FLASH_EN defined:
//   - In FAULT, o_flash_red toggles every FLASH_DIV cycles, starting at 1 on the first FAULT cycle.
//   - Outside FAULT, o_flash_red=0.
//  Not defined: o_flash_red is tied to 0 and no divider logic exists.
// TESTING
//  1 Reset, then drive 001100 for 10 cycles -> o_valid=1 two cycles later, o_G=00, o_fault=0.
//  2 Cycle 00(8)->01(3)->11(8)->10(3)->00 -> four o_phase_done pulses; o_phase_len=8,3,8,3; no fault.
//  3 Hold 00 for 5 cycles, then 01 -> o_phase_done with o_phase_len=5; o_fault=1, code 3.
//  4 Hold 01 for 6 cycles -> code 4 on the 6th counted cycle. Then i_clear -> o_fault=0, INIT. Next 001100 -> TRACK.
//  5 In TRACK, drive 101100 (main red and green both on) -> code 1. Separately, go 00->11 -> code 2, with no o_phase_done.
//  6 With TRAFFIC_MON_FLASH_EN defined, force a fault -> o_flash_red = 1,1,1,1,0,0,0,0,1...
//    Without the macro, o_flash_red stays 0.

Source files
------------

// File: rtl/traffic_lamp_monitor.sv
// Traffic-light lamp monitor: decodes the six lamps back to the Gray state and checks phase order and durations.
// Optional build macro TRAFFIC_MON_FLASH_EN enables the fail-safe flashing red output in FAULT.
module traffic_lamp_monitor #(
   parameter int CNT_W     = 8,
   parameter int MIN_LONG  = 8,
   parameter int MIN_SHORT = 2,
   parameter int MAX_SHORT = 6,
   parameter int FLASH_DIV = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_Main_red,
   input  logic             i_Main_yellow,
   input  logic             i_Main_green,
   input  logic             i_Side_red,
   input  logic             i_Side_yellow,
   input  logic             i_Side_green,
   output logic [1:0]       o_G,
   output logic             o_valid,
   output logic             o_phase_done,
   output logic [CNT_W-1:0] o_phase_len,
   output logic             o_fault,
   output logic [2:0]       o_fault_code,
   output logic             o_flash_red
);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   localparam logic [2:0] CODE_PATTERN = 3'd1;
   localparam logic [2:0] CODE_ORDER   = 3'd2;
   localparam logic [2:0] CODE_SHORT   = 3'd3;
   localparam logic [2:0] CODE_TIMEOUT = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_LONG_C  = CNT_W'(MIN_LONG);
   localparam logic [CNT_W-1:0] MIN_SHORT_C = CNT_W'(MIN_SHORT);
   localparam logic [CNT_W-1:0] MAX_SHORT_C = CNT_W'(MAX_SHORT);

   if (MAX_SHORT <= MIN_SHORT || FLASH_DIV < 1) begin : g_param_check
      $error("traffic_lamp_monitor: need MAX_SHORT > MIN_SHORT and FLASH_DIV >= 1");
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   function automatic logic [1:0] gray_next(input logic [1:0] g);
      case (g)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   logic [5:0]       lamp_q, lamp_d;
   logic [1:0]       st_q, st_d;
   logic [1:0]       g_q, g_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             fault_q, fault_d;
   logic [2:0]       code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [2:0]       trip;
   logic             pat_ok;
   logic [1:0]       pat_g;
   logic             phase_short;

   // Stage 1: lamp capture
   assign lamp_d = {i_Main_red, i_Main_yellow, i_Main_green,
                    i_Side_red, i_Side_yellow, i_Side_green};

   // Stage 2: decode and sequence checking
   always_comb begin
      pat_ok = 1'b1;
      pat_g  = 2'b00;
      case (lamp_q)
         6'b001100: pat_g = 2'b00;
         6'b010100: pat_g = 2'b01;
         6'b100001: pat_g = 2'b11;
         6'b100010: pat_g = 2'b10;
         default:   pat_ok = 1'b0;
      endcase
   end

   always_comb begin
      st_d        = st_q;
      g_d         = g_q;
      valid_d     = valid_q;
      done_d      = 1'b0;
      len_d       = len_q;
      fault_d     = fault_q;
      code_d      = code_q;
      cnt_d       = cnt_q;
      trip        = 3'd0;
      cnt_inc     = sat_inc(cnt_q);
      // Yellow states have odd Gray parity; greens need the longer minimum.
      phase_short = (g_q[1] ^ g_q[0]) ? (cnt_q < MIN_SHORT_C) : (cnt_q < MIN_LONG_C);
      if (i_clear) begin
         st_d    = ST_INIT;
         valid_d = 1'b0;
         fault_d = 1'b0;
         code_d  = 3'd0;
         cnt_d   = '0;
      end else begin
         case (st_q)
            ST_INIT: begin
               if (pat_ok) begin
                  st_d    = ST_TRACK;
                  g_d     = pat_g;
                  cnt_d   = CNT_ONE;
                  valid_d = 1'b1;
               end
            end
            ST_TRACK: begin
               if (!pat_ok) begin
                  trip = CODE_PATTERN;
               end else if (pat_g == g_q) begin
                  cnt_d = cnt_inc;
                  if ((g_q[1] ^ g_q[0]) && cnt_inc >= MAX_SHORT_C) trip = CODE_TIMEOUT;
               end else if (pat_g != gray_next(g_q)) begin
                  g_d  = pat_g;
                  trip = CODE_ORDER;
               end else begin
                  len_d  = cnt_q;
                  done_d = 1'b1;
                  cnt_d  = CNT_ONE;
                  g_d    = pat_g;
                  if (phase_short) trip = CODE_SHORT;
               end
            end
            default: ;
         endcase
         if (trip != 3'd0) begin
            st_d    = ST_FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
            code_d  = trip;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         lamp_q  <= '0;
         st_q    <= ST_INIT;
         g_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         len_q   <= '0;
         fault_q <= 1'b0;
         code_q  <= '0;
         cnt_q   <= '0;
      end else begin
         lamp_q  <= lamp_d;
         st_q    <= st_d;
         g_q     <= g_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         len_q   <= len_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef TRAFFIC_MON_FLASH_EN
   localparam int DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic             flash_q, flash_d;
   logic [DIV_W-1:0] div_q, div_d;

   // Flash starts lit on the same edge the fault is latched.
   always_comb begin
      flash_d = 1'b0;
      div_d   = '0;
      if (!i_clear) begin
         if (st_q == ST_FAULT) begin
            if (div_q == DIV_LAST) begin
               flash_d = ~flash_q;
               div_d   = '0;
            end else begin
               flash_d = flash_q;
               div_d   = div_q + DIV_ONE;
            end
         end else if (trip != 3'd0) begin
            flash_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         flash_q <= 1'b0;
         div_q   <= '0;
      end else begin
         flash_q <= flash_d;
         div_q   <= div_d;
      end
   end

   assign o_flash_red = flash_q;
`else
   assign o_flash_red = 1'b0;
`endif

   assign o_G          = g_q;
   assign o_valid      = valid_q;
   assign o_phase_done = done_q;
   assign o_phase_len  = len_q;
   assign o_fault      = fault_q;
   assign o_fault_code = code_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: directed scenarios plus randomized lamp sequences against a reference model.
module tb_traffic_lamp_monitor;
   localparam int CNT_W     = 8;
   localparam int MIN_LONG  = 8;
   localparam int MIN_SHORT = 2;
   localparam int MAX_SHORT = 6;
   localparam int FLASH_DIV = 4;
   localparam int CNT_SAT   = (1 << CNT_W) - 1;

   localparam logic [5:0] P00 = 6'b001100;
   localparam logic [5:0] P01 = 6'b010100;
   localparam logic [5:0] P11 = 6'b100001;
   localparam logic [5:0] P10 = 6'b100010;

`ifdef TRAFFIC_MON_FLASH_EN
   localparam bit FLASH_ON = 1'b1;
`else
   localparam bit FLASH_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, clr;
   logic [5:0]       lamps;
   logic [1:0]       o_G;
   logic             o_valid, o_phase_done, o_fault, o_flash_red;
   logic [CNT_W-1:0] o_phase_len;
   logic [2:0]       o_fault_code;

   always #5 clk = ~clk;

   traffic_lamp_monitor #(
      .CNT_W(CNT_W), .MIN_LONG(MIN_LONG), .MIN_SHORT(MIN_SHORT),
      .MAX_SHORT(MAX_SHORT), .FLASH_DIV(FLASH_DIV)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_clear(clr),
      .i_Main_red(lamps[5]), .i_Main_yellow(lamps[4]), .i_Main_green(lamps[3]),
      .i_Side_red(lamps[2]), .i_Side_yellow(lamps[1]), .i_Side_green(lamps[0]),
      .o_G(o_G), .o_valid(o_valid), .o_phase_done(o_phase_done),
      .o_phase_len(o_phase_len), .o_fault(o_fault), .o_fault_code(o_fault_code),
      .o_flash_red(o_flash_red)
   );

   // The legal cycle as a ring: index k follows k-1; odd indices are yellow phases.
   logic [5:0] seq_p [4];
   logic [1:0] seq_g [4];
   initial begin
      seq_p[0] = P00; seq_p[1] = P01; seq_p[2] = P11; seq_p[3] = P10;
      seq_g[0] = 2'b00; seq_g[1] = 2'b01; seq_g[2] = 2'b11; seq_g[3] = 2'b10;
   end

   function automatic int ring_pos(input logic [5:0] p);
      for (int i = 0; i < 4; i++) if (p == seq_p[i]) return i;
      return -1;
   endfunction

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 = waiting, 1 = tracking, 2 = faulted.
   int         m_mode = 0, m_pos = 0, m_cnt = 0, m_len = 0, m_code = 0, m_fc = 0;
   logic [1:0] m_g = 2'b00;
   bit         m_valid = 0, m_done = 0, m_fault = 0, m_flash = 0;
   logic [5:0] m_rlamp = 6'd0;
   int         mp;
   bit         m_short;

   task automatic m_trip(input int c);
      m_mode  = 2;
      m_fault = 1'b1;
      m_valid = 1'b0;
      m_code  = c;
      m_fc    = 0;
   endtask

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
         m_mode = 0; m_g = 2'b00; m_valid = 0; m_len = 0; m_fault = 0;
         m_code = 0; m_cnt = 0; m_fc = 0;
      end else if (clr) begin
         m_mode = 0; m_valid = 0; m_fault = 0; m_code = 0; m_cnt = 0;
      end else begin
         mp = ring_pos(m_rlamp);
         if (m_mode == 0) begin
            if (mp >= 0) begin
               m_mode = 1; m_pos = mp; m_g = seq_g[mp]; m_cnt = 1; m_valid = 1;
            end
         end else if (m_mode == 1) begin
            if (mp < 0) m_trip(1);
            else if (mp == m_pos) begin
               if (m_cnt < CNT_SAT) m_cnt++;
               if ((m_pos % 2 == 1) && m_cnt >= MAX_SHORT) m_trip(4);
            end else if (mp != (m_pos + 1) % 4) begin
               m_pos = mp; m_g = seq_g[mp];
               m_trip(2);
            end else begin
               m_short = (m_pos % 2 == 1) ? (m_cnt < MIN_SHORT) : (m_cnt < MIN_LONG);
               m_len = m_cnt; m_done = 1; m_cnt = 1; m_pos = mp; m_g = seq_g[mp];
               if (m_short) m_trip(3);
            end
         end else begin
            m_fc++;
         end
      end
      m_flash = FLASH_ON && (m_mode == 2) && ((m_fc / FLASH_DIV) % 2 == 0);
      m_rlamp = rst ? 6'd0 : lamps;
   end

   int unsigned ph_q [$];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("o_G", 32'(o_G), 32'(m_g));
         chk("o_valid", 32'(o_valid), 32'(m_valid));
         chk("o_phase_done", 32'(o_phase_done), 32'(m_done));
         chk("o_phase_len", 32'(o_phase_len), 32'(m_len));
         chk("o_fault", 32'(o_fault), 32'(m_fault));
         chk("o_fault_code", 32'(o_fault_code), 32'(m_code));
         chk("o_flash_red", 32'(o_flash_red), 32'(m_flash));
         if (o_phase_done === 1'b1) ph_q.push_back(32'(o_phase_len));
      end
   end

   task automatic hold(input logic [5:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         lamps = p;
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; lamps = 6'd0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_clear(input logic [5:0] p);
      clr = 1'b1; lamps = p;
      @(negedge clk);
      clr = 1'b0;
   endtask

   int rr, r_pos;

   initial begin
      rst = 1'b1; clr = 1'b0; lamps = 6'd0;
      @(negedge clk);
      do_reset();
      chk("reset valid", 32'(o_valid), 0);
      chk("reset fault", 32'(o_fault), 0);
      chk("reset len", 32'(o_phase_len), 0);

      // Two-cycle latency to TRACK
      hold(P00, 1);
      chk("t1 valid latency", 32'(o_valid), 0);
      hold(P00, 1);
      chk("t1 valid", 32'(o_valid), 1);
      chk("t1 G", 32'(o_G), 0);
      hold(P00, 8);
      chk("t1 fault", 32'(o_fault), 0);

      // Full legal cycle
      do_reset();
      ph_q.delete();
      hold(P00, 8); hold(P01, 3); hold(P11, 8); hold(P10, 3); hold(P00, 3);
      chk("t2 pulses", 32'(ph_q.size()), 4);
      if (ph_q.size() == 4) begin
         chk("t2 len0", ph_q[0], 8);
         chk("t2 len1", ph_q[1], 3);
         chk("t2 len2", ph_q[2], 8);
         chk("t2 len3", ph_q[3], 3);
      end
      chk("t2 fault", 32'(o_fault), 0);

      // Short green
      do_reset();
      hold(P00, 5); hold(P01, 2);
      chk("t3 done", 32'(o_phase_done), 1);
      chk("t3 len", 32'(o_phase_len), 5);
      chk("t3 fault", 32'(o_fault), 1);
      chk("t3 code", 32'(o_fault_code), 3);
      chk("t3 flash first", 32'(o_flash_red), 32'(FLASH_ON));
      hold(P01, 4);
      chk("t3 flash after div", 32'(o_flash_red), 0);

      // Yellow timeout, then clear and re-acquire
      do_reset();
      hold(P00, 8); hold(P01, 6);
      chk("t4 no fault yet", 32'(o_fault), 0);
      hold(P01, 1);
      chk("t4 code", 32'(o_fault_code), 4);
      pulse_clear(P00);
      chk("t4 cleared", 32'(o_fault), 0);
      chk("t4 cleared valid", 32'(o_valid), 0);
      chk("t4 cleared code", 32'(o_fault_code), 0);
      hold(P00, 1);
      chk("t4 retrack", 32'(o_valid), 1);

      // Illegal pattern and illegal transition
      do_reset();
      hold(P00, 3); hold(6'b101100, 2);
      chk("t5 code1", 32'(o_fault_code), 1);
      chk("t5 G held", 32'(o_G), 0);
      do_reset();
      hold(P00, 8); hold(P11, 2);
      chk("t5 code2", 32'(o_fault_code), 2);
      chk("t5 no done", 32'(o_phase_done), 0);

      // Boundary phase lengths: minimum yellow, longest legal yellow, saturated green
      do_reset();
      hold(P00, 8); hold(P01, 2); hold(P11, 2);
      chk("min yellow len", 32'(o_phase_len), 2);
      chk("min yellow ok", 32'(o_fault), 0);
      hold(P11, 6); hold(P10, 5); hold(P00, 2);
      chk("max yellow len", 32'(o_phase_len), 5);
      chk("max yellow ok", 32'(o_fault), 0);
      hold(P00, 300); hold(P01, 2);
      chk("sat len", 32'(o_phase_len), CNT_SAT);

      // Randomized sequences
      do_reset();
      r_pos = 0;
      hold(P00, 9);
      for (int k = 0; k < 400; k++) begin
         rr = int'($urandom_range(0, 99));
         if (m_mode == 2 && rr < 60) pulse_clear(seq_p[r_pos]);
         else if (rr < 5) hold(6'($urandom), int'($urandom_range(1, 3)));
         else if (rr < 9) begin
            r_pos = int'($urandom_range(0, 3));
            hold(seq_p[r_pos], int'($urandom_range(1, 10)));
         end else if (rr < 11) pulse_clear(seq_p[r_pos]);
         else if (rr == 99) begin
            do_reset();
            r_pos = 0;
            hold(P00, 9);
         end else begin
            r_pos = (r_pos + 1) % 4;
            hold(seq_p[r_pos], (r_pos % 2 == 0) ? int'($urandom_range(6, 14))
                                                : int'($urandom_range(1, 7)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
